chimera_clu_gate_ctrl: RTL and testbench

CHIMERA_CLU_GATE_CTRL -- requirements
Module: chimera_clu_gate_ctrl

---
 rtl/chimera_pkg.sv | 26 ++
 rtl/chimera_clu_gate_fsm.sv | 157 +++++++++++++++
 rtl/chimera_clu_gate_ctrl.sv | 56 +++++
 tb/tb_chimera_clu_gate_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chimera_pkg.sv
// ============================================================================
// Module      : chimera_pkg
// Description : Shared types and default constants for the cluster clock-gate
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chimera_pkg;

    // Per-cluster gating state.
    typedef enum logic [1:0] {
        CLU_RUN   = 2'd0,
        CLU_DRAIN = 2'd1,
        CLU_GATED = 2'd2,
        CLU_WAKE  = 2'd3
    } clu_gate_state_e;

    // Clock cycles spent under isolation after ungating, before release.
    localparam int unsigned c_WAKE_CYCLES   = 4;
    // DRAIN cycles tolerated before gating is forced (timeout build only).
    localparam int unsigned c_DRAIN_TIMEOUT = 1024;

endpackage

`default_nettype wire

// File: rtl/chimera_clu_gate_fsm.sv
// ============================================================================
// Module      : chimera_clu_gate_fsm
// Description : Gate-control FSM for one cluster clock domain: tracks the
//               outstanding AXI transactions, drains them under isolation,
//               gates the clock and sequences the wake-up.
//               Optional forced gating: CHIMERA_CLU_GATE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chimera_clu_gate_fsm
    import chimera_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 8,
`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
    parameter int unsigned DRAIN_TIMEOUT   = c_DRAIN_TIMEOUT,
`endif
    parameter int unsigned WAKE_CYCLES     = c_WAKE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic gate_req_i,
    input  logic txn_start_i,
    input  logic txn_done_i,
    output logic isolate_o,
    output logic clk_en_o,
    output logic gated_o,
    output logic timeout_o
);

    localparam int unsigned        c_CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [7:0]         c_WAKE_LOAD = 8'(WAKE_CYCLES - 1);

    clu_gate_state_e    r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [7:0]         r_wake;
    logic               r_isolate;
    logic               r_clk_en;
    logic               r_gated;
    logic               w_drained;
    logic               w_force_gate;

    // Saturating outstanding count; simultaneous start and done cancel out.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (txn_start_i && !txn_done_i && (r_cnt != c_CNT_MAX)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (txn_done_i && !txn_start_i && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // The last response retiring on this edge already allows gating.
    assign w_drained = (w_cnt_nxt == '0) && !txn_start_i;

`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
    localparam int unsigned        c_TMO_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(DRAIN_TIMEOUT - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_timeout;
    logic               w_enter_run;

    assign w_force_gate = (r_state == CLU_DRAIN) && gate_req_i && !w_drained &&
                          (r_tmo_cnt == c_TMO_LAST);
    assign w_enter_run  = ((r_state == CLU_DRAIN) && !gate_req_i) ||
                          ((r_state == CLU_WAKE) && (r_wake == '0));

    // DRAIN age counter and sticky forced-gating flag, cleared on entry to RUN.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == CLU_DRAIN) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_force_gate) begin
                r_timeout <= 1'b1;
            end else if (w_enter_run) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_force_gate = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // Gate sequencing with outputs registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= CLU_RUN;
            r_cnt     <= '0;
            r_wake    <= '0;
            r_isolate <= 1'b0;
            r_clk_en  <= 1'b1;
            r_gated   <= 1'b0;
        end else begin
            // Forced gating abandons the in-flight transactions.
            r_cnt <= w_force_gate ? '0 : w_cnt_nxt;
            case (r_state)
                CLU_RUN: begin
                    if (gate_req_i) begin
                        r_state   <= CLU_DRAIN;
                        r_isolate <= 1'b1;
                    end
                end
                CLU_DRAIN: begin
                    if (!gate_req_i) begin
                        r_state   <= CLU_RUN;
                        r_isolate <= 1'b0;
                    end else if (w_drained || w_force_gate) begin
                        r_state  <= CLU_GATED;
                        r_clk_en <= 1'b0;
                        r_gated  <= 1'b1;
                    end
                end
                CLU_GATED: begin
                    if (!gate_req_i) begin
                        r_state  <= CLU_WAKE;
                        r_clk_en <= 1'b1;
                        r_gated  <= 1'b0;
                        r_wake   <= c_WAKE_LOAD;
                    end
                end
                CLU_WAKE: begin
                    if (r_wake == '0) begin
                        r_state   <= CLU_RUN;
                        r_isolate <= 1'b0;
                    end else begin
                        r_wake <= r_wake - 1'b1;
                    end
                end
                default: begin
                    r_state   <= CLU_RUN;
                    r_isolate <= 1'b0;
                    r_clk_en  <= 1'b1;
                    r_gated   <= 1'b0;
                end
            endcase
        end
    end

    assign isolate_o = r_isolate;
    assign clk_en_o  = r_clk_en;
    assign gated_o   = r_gated;

endmodule

`default_nettype wire

// File: rtl/chimera_clu_gate_ctrl.sv
// ============================================================================
// Module      : chimera_clu_gate_ctrl
// Description : Clock-gate controller for NUM_CLUSTERS cluster domains; one
//               independent gate FSM per cluster.
//               Optional forced gating: CHIMERA_CLU_GATE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chimera_clu_gate_ctrl
    import chimera_pkg::*;
#(
    parameter int unsigned NUM_CLUSTERS    = 5,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned WAKE_CYCLES     = c_WAKE_CYCLES,
    parameter int unsigned DRAIN_TIMEOUT   = c_DRAIN_TIMEOUT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CLUSTERS-1:0] gate_req_i,
    input  logic [NUM_CLUSTERS-1:0] txn_start_i,
    input  logic [NUM_CLUSTERS-1:0] txn_done_i,
    output logic [NUM_CLUSTERS-1:0] isolate_o,
    output logic [NUM_CLUSTERS-1:0] clk_en_o,
    output logic [NUM_CLUSTERS-1:0] gated_o,
    output logic [NUM_CLUSTERS-1:0] timeout_o
);

    // The wake counter is eight bits wide.
    if ((WAKE_CYCLES < 1) || (WAKE_CYCLES > 255) || (DRAIN_TIMEOUT < 1)) begin : g_bad_params
        $error("chimera_clu_gate_ctrl: WAKE_CYCLES must be 1..255 and DRAIN_TIMEOUT >= 1");
    end

    for (genvar g = 0; g < NUM_CLUSTERS; g++) begin : g_cluster
        chimera_clu_gate_fsm #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
            .DRAIN_TIMEOUT   (DRAIN_TIMEOUT),
`endif
            .WAKE_CYCLES     (WAKE_CYCLES)
        ) u_fsm (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .gate_req_i  (gate_req_i[g]),
            .txn_start_i (txn_start_i[g]),
            .txn_done_i  (txn_done_i[g]),
            .isolate_o   (isolate_o[g]),
            .clk_en_o    (clk_en_o[g]),
            .gated_o     (gated_o[g]),
            .timeout_o   (timeout_o[g])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_chimera_clu_gate_ctrl.sv
// ============================================================================
// Module      : tb_chimera_clu_gate_ctrl
// Description : Self-checking bench for chimera_clu_gate_ctrl: directed vector
//               table, hand-written corner sequences and a random run against
//               a behavioural model. Honours CHIMERA_CLU_GATE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chimera_clu_gate_ctrl;

    localparam int c_NC = 5;
    localparam int c_MO = 8;
    localparam int c_WC = 4;
    localparam int c_DT = 16;
`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
    localparam bit c_TMO_ON = 1'b1;
`else
    localparam bit c_TMO_ON = 1'b0;
`endif

    // Model modes: running, draining, clock off, waking up.
    localparam int c_RUNNING = 0;
    localparam int c_DRAINING = 1;
    localparam int c_OFF = 2;
    localparam int c_WAKING = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [c_NC-1:0] gate_req_i = '0;
    logic [c_NC-1:0] txn_start_i = '0;
    logic [c_NC-1:0] txn_done_i = '0;
    logic [c_NC-1:0] isolate_o;
    logic [c_NC-1:0] clk_en_o;
    logic [c_NC-1:0] gated_o;
    logic [c_NC-1:0] timeout_o;

    chimera_clu_gate_ctrl #(
        .NUM_CLUSTERS    (c_NC),
        .MAX_OUTSTANDING (c_MO),
        .WAKE_CYCLES     (c_WC),
        .DRAIN_TIMEOUT   (c_DT)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .gate_req_i  (gate_req_i),
        .txn_start_i (txn_start_i),
        .txn_done_i  (txn_done_i),
        .isolate_o   (isolate_o),
        .clk_en_o    (clk_en_o),
        .gated_o     (gated_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;

    // Behavioural model state per cluster.
    int m_mode[c_NC];
    int m_out[c_NC];   // transactions in flight
    int m_age[c_NC];   // DRAIN cycles already completed
    int m_left[c_NC];  // WAKE cycles still to run
    bit m_tmo[c_NC];

    typedef struct {
        logic [c_NC-1:0] req;
        logic [c_NC-1:0] st;
        logic [c_NC-1:0] dn;
        logic [c_NC-1:0] iso;
        logic [c_NC-1:0] en;
        logic [c_NC-1:0] gtd;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [c_NC-1:0] act, input logic [c_NC-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%b required=%b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst_n, input logic [c_NC-1:0] req,
                              input logic [c_NC-1:0] st, input logic [c_NC-1:0] dn);
        for (int c = 0; c < c_NC; c++) begin
            int nxt;
            if (!rst_n) begin
                m_mode[c] = c_RUNNING;
                m_out[c]  = 0;
                m_age[c]  = 0;
                m_left[c] = 0;
                m_tmo[c]  = 1'b0;
                continue;
            end
            nxt = m_out[c];
            if (st[c] && !dn[c] && m_out[c] < c_MO) nxt = nxt + 1;
            if (dn[c] && !st[c] && m_out[c] > 0) nxt = nxt - 1;
            case (m_mode[c])
                c_RUNNING: if (req[c]) begin m_mode[c] = c_DRAINING; m_age[c] = 0; end
                c_DRAINING: begin
                    if (!req[c]) begin
                        m_mode[c] = c_RUNNING;
                        m_tmo[c]  = 1'b0;
                    end else if (nxt == 0 && !st[c]) begin
                        m_mode[c] = c_OFF;
                    end else if (c_TMO_ON && m_age[c] + 1 >= c_DT) begin
                        m_mode[c] = c_OFF;
                        m_tmo[c]  = 1'b1;
                        nxt       = 0;
                    end else begin
                        m_age[c] = m_age[c] + 1;
                    end
                end
                c_OFF: if (!req[c]) begin m_mode[c] = c_WAKING; m_left[c] = c_WC; end
                default: begin
                    m_left[c] = m_left[c] - 1;
                    if (m_left[c] == 0) begin m_mode[c] = c_RUNNING; m_tmo[c] = 1'b0; end
                end
            endcase
            m_out[c] = nxt;
        end
    endtask

    task automatic model_check(input string tag);
        logic [c_NC-1:0] e_iso, e_en, e_gtd, e_tmo;
        for (int c = 0; c < c_NC; c++) begin
            e_iso[c] = (m_mode[c] != c_RUNNING);
            e_en[c]  = (m_mode[c] != c_OFF);
            e_gtd[c] = (m_mode[c] == c_OFF);
            e_tmo[c] = m_tmo[c];
        end
        check({tag, ".isolate"}, isolate_o, e_iso);
        check({tag, ".clk_en"},  clk_en_o,  e_en);
        check({tag, ".gated"},   gated_o,   e_gtd);
        check({tag, ".timeout"}, timeout_o, e_tmo);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic step(input logic [c_NC-1:0] req, input logic [c_NC-1:0] st,
                        input logic [c_NC-1:0] dn, input bit rst_n);
        gate_req_i  = req;
        txn_start_i = st;
        txn_done_i  = dn;
        rst_ni      = rst_n;
        @(posedge clk_i);
        model_edge(rst_n, req, st, dn);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [c_NC-1:0] iso,
                              input logic [c_NC-1:0] en, input logic [c_NC-1:0] gtd,
                              input logic [c_NC-1:0] tmo);
        check({name, ".isolate"}, isolate_o, iso);
        check({name, ".clk_en"},  clk_en_o,  en);
        check({name, ".gated"},   gated_o,   gtd);
        check({name, ".timeout"}, timeout_o, tmo);
    endtask

    function automatic void add(input logic [c_NC-1:0] req, input logic [c_NC-1:0] st,
                                input logic [c_NC-1:0] dn, input logic [c_NC-1:0] iso,
                                input logic [c_NC-1:0] en, input logic [c_NC-1:0] gtd);
        vec_t v;
        v.req = req; v.st = st; v.dn = dn; v.iso = iso; v.en = en; v.gtd = gtd;
        tbl.push_back(v);
    endfunction

    initial begin
        int n;
        logic [c_NC-1:0] rq, rs, rd;

        // Idle gating and wake on cluster 2.
        add(5'b00100, 5'b00000, 5'b00000, 5'b00100, 5'b11111, 5'b00000);
        add(5'b00100, 5'b00000, 5'b00000, 5'b00100, 5'b11011, 5'b00100);
        add(5'b00100, 5'b00000, 5'b00000, 5'b00100, 5'b11011, 5'b00100);
        add(5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b11111, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b11111, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b11111, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b11111, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000);
        // Drain wait on cluster 0: three starts, request, three dones.
        add(5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b11111, 5'b00000);
        add(5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b11111, 5'b00000);
        add(5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b11111, 5'b00000);
        add(5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b11111, 5'b00000);
        add(5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b11111, 5'b00000);
        add(5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b11111, 5'b00000);
        add(5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b11111, 5'b00000);
        add(5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b11110, 5'b00001);
        add(5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b11111, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b11111, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b11111, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b11111, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000);
        // Cluster 1: start+done at count 2; cluster 3: done at count 0.
        add(5'b00000, 5'b00010, 5'b01000, 5'b00000, 5'b11111, 5'b00000);
        add(5'b00000, 5'b01010, 5'b00000, 5'b00000, 5'b11111, 5'b00000);
        add(5'b00000, 5'b00010, 5'b00010, 5'b00000, 5'b11111, 5'b00000);
        add(5'b01010, 5'b00000, 5'b00000, 5'b01010, 5'b11111, 5'b00000);
        add(5'b01010, 5'b00000, 5'b00010, 5'b01010, 5'b11111, 5'b00000);
        add(5'b01010, 5'b00000, 5'b01010, 5'b01010, 5'b10101, 5'b01010);

        // Reset state.
        step('0, '0, '0, 1'b0);
        step('0, '0, '0, 1'b0);
        expect_out("reset", 5'b00000, 5'b11111, 5'b00000, 5'b00000);

        // Directed vector table.
        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].st, tbl[i].dn, 1'b1);
            expect_out($sformatf("vec%0d", i), tbl[i].iso, tbl[i].en, tbl[i].gtd, 5'b00000);
        end

        // Reset while clusters 1 and 3 are gated, request still high.
        step(5'b01010, '0, '0, 1'b0);
        expect_out("rst_gated", 5'b00000, 5'b11111, 5'b00000, 5'b00000);
        step('0, '0, '0, 1'b1);
        expect_out("rst_after", 5'b00000, 5'b11111, 5'b00000, 5'b00000);

        // Cluster 4: WAKE ignores a re-request, then RUN, then DRAIN, then abort.
        step(5'b10000, '0, '0, 1'b1);
        expect_out("w4_drain", 5'b10000, 5'b11111, 5'b00000, 5'b00000);
        step(5'b10000, '0, '0, 1'b1);
        expect_out("w4_gated", 5'b10000, 5'b01111, 5'b10000, 5'b00000);
        step('0, '0, '0, 1'b1);
        expect_out("w4_wake1", 5'b10000, 5'b11111, 5'b00000, 5'b00000);
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);
        step(5'b10000, '0, '0, 1'b1);
        expect_out("w4_wake4", 5'b10000, 5'b11111, 5'b00000, 5'b00000);
        step(5'b10000, '0, '0, 1'b1);
        expect_out("w4_run", 5'b00000, 5'b11111, 5'b00000, 5'b00000);
        step(5'b10000, '0, '0, 1'b1);
        expect_out("w4_redrain", 5'b10000, 5'b11111, 5'b00000, 5'b00000);
        step('0, '0, '0, 1'b1);
        expect_out("w4_abort", 5'b00000, 5'b11111, 5'b00000, 5'b00000);

        // Cluster 0 with one transaction that never completes.
        step('0, 5'b00001, '0, 1'b1);
        step(5'b00001, '0, '0, 1'b1);
        n = 0;
`ifdef CHIMERA_CLU_GATE_TIMEOUT_EN
        while (gated_o[0] !== 1'b1 && n < 40) begin
            step(5'b00001, '0, '0, 1'b1);
            n++;
        end
        check_int("tmo_drain_cycles", n, c_DT);
        expect_out("tmo_gated", 5'b00001, 5'b11110, 5'b00001, 5'b00001);
        step('0, '0, '0, 1'b1);
        expect_out("tmo_wake", 5'b00001, 5'b11111, 5'b00000, 5'b00001);
        for (int k = 0; k < c_WC; k++) step('0, '0, '0, 1'b1);
        expect_out("tmo_run", 5'b00000, 5'b11111, 5'b00000, 5'b00000);
        // Forced gating dropped the stuck transaction: idle gating follows.
        step(5'b00001, '0, '0, 1'b1);
        step(5'b00001, '0, '0, 1'b1);
        expect_out("tmo_regate", 5'b00001, 5'b11110, 5'b00001, 5'b00000);
        step('0, '0, '0, 1'b1);
        for (int k = 0; k < c_WC; k++) step('0, '0, '0, 1'b1);
`else
        while (gated_o[0] !== 1'b1 && n < 100) begin
            step(5'b00001, '0, '0, 1'b1);
            n++;
        end
        check_int("drain_hold_cycles", n, 100);
        expect_out("drain_hold", 5'b00001, 5'b11111, 5'b00000, 5'b00000);
        step('0, '0, 5'b00001, 1'b1);
        expect_out("drain_abort", 5'b00000, 5'b11111, 5'b00000, 5'b00000);
`endif

        // Random traffic against the behavioural model.
        step('0, '0, '0, 1'b0);
        model_check("rnd_reset");
        rq = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < c_NC; c++) begin
                if ($urandom_range(0, 15) == 0) rq[c] = ~rq[c];
                rs[c] = ($urandom_range(0, 3) == 0);
                rd[c] = ($urandom_range(0, 3) == 0);
            end
            step(rq, rs, rd, ($urandom_range(0, 499) != 0));
            model_check($sformatf("rnd%0d", cyc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
